// File: rtl/rst_sequencer.sv
// PLL reset / lock qualification / staggered domain reset release sequencer.
// Optional macro LOCK_WATCHDOG_EN adds a WAIT_LOCK timeout that re-resets the PLL.
//   state     | meaning
//   PLL_RST   | pll_resetb held low for PLL_RST_CYCLES, all domains in reset
//   WAIT_LOCK | waiting for LOCK_STABLE consecutive cycles of synchronized lock
//   RELEASE   | domain resets drop one at a time, GAP cycles apart, bit 0 first
//   RUN       | all domains out of reset, ready high
module rst_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_STABLE    = 16,
  parameter int GAP            = 8,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_lock,
  input  logic                 sw_req,
  output logic                 pll_resetb,
  output logic [N_DOMAINS-1:0] dom_rst,
  output logic                 ready,
  output logic [1:0]           state,
  output logic [3:0]           retry_cnt
);

  localparam int TW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam int GW = $clog2(GAP) + 1;

  if (N_DOMAINS < 1 || N_DOMAINS > 8 || PLL_RST_CYCLES < 1 || LOCK_STABLE < 1 ||
      GAP < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("rst_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, lock_s_q;
  logic [TW-1:0]          rst_tmr_q, rst_tmr_d;
  logic [SW-1:0]          stable_q, stable_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   pll_resetb_q, pll_resetb_d;
  logic [N_DOMAINS-1:0]   dom_rst_q, dom_rst_d;
  logic                   ready_q, ready_d;

`ifdef LOCK_WATCHDOG_EN
  localparam int WW = $clog2(LOCK_TIMEOUT) + 1;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    retry_q, retry_d;
`endif

  always_comb begin
    state_d      = state_q;
    rst_tmr_d    = rst_tmr_q;
    stable_d     = stable_q;
    gap_d        = gap_q;
    pll_resetb_d = pll_resetb_q;
    dom_rst_d    = dom_rst_q;
    ready_d      = ready_q;
`ifdef LOCK_WATCHDOG_EN
    wd_d    = (state_q == WAIT_LOCK) ? wd_q + 1'b1 : '0;
    retry_d = retry_q;
`endif
    case (state_q)
      PLL_RST: begin
        pll_resetb_d = 1'b0;
        dom_rst_d    = '1;
        ready_d      = 1'b0;
        if (rst_tmr_q == TW'(PLL_RST_CYCLES - 1)) begin
          state_d      = WAIT_LOCK;
          pll_resetb_d = 1'b1;
          rst_tmr_d    = '0;
          stable_d     = '0;
        end else begin
          rst_tmr_d = rst_tmr_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          stable_d = '0;
        end else if (stable_q == SW'(LOCK_STABLE - 1)) begin
          // Domains clear lowest-first, so a left shift drops exactly the next one.
          state_d   = RELEASE;
          gap_d     = '0;
          dom_rst_d = dom_rst_q << 1;
          if (dom_rst_d == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          stable_d = stable_q + 1'b1;
        end
`ifdef LOCK_WATCHDOG_EN
        if (state_d == WAIT_LOCK && wd_q == WW'(LOCK_TIMEOUT - 1)) begin
          state_d      = PLL_RST;
          pll_resetb_d = 1'b0;
          rst_tmr_d    = '0;
          if (retry_q != 4'hF) retry_d = retry_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (gap_q == GW'(GAP - 1)) begin
          gap_d     = '0;
          dom_rst_d = dom_rst_q << 1;
          if (dom_rst_d == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RUN: ready_d = 1'b1;
    endcase

    // A software request outranks a simultaneous lock loss.
    if (state_q == RELEASE || state_q == RUN) begin
      if (sw_req) begin
        state_d      = PLL_RST;
        pll_resetb_d = 1'b0;
        dom_rst_d    = '1;
        ready_d      = 1'b0;
        rst_tmr_d    = '0;
      end else if (!lock_s_q) begin
        state_d   = WAIT_LOCK;
        dom_rst_d = '1;
        ready_d   = 1'b0;
        stable_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PLL_RST;
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      rst_tmr_q    <= '0;
      stable_q     <= '0;
      gap_q        <= '0;
      pll_resetb_q <= 1'b0;
      dom_rst_q    <= '1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= pll_lock;
      lock_s_q     <= sync1_q;
      rst_tmr_q    <= rst_tmr_d;
      stable_q     <= stable_d;
      gap_q        <= gap_d;
      pll_resetb_q <= pll_resetb_d;
      dom_rst_q    <= dom_rst_d;
      ready_q      <= ready_d;
    end
  end

`ifdef LOCK_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      retry_q <= '0;
    end else begin
      wd_q    <= wd_d;
      retry_q <= retry_d;
    end
  end
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = 4'd0;
`endif

  assign state      = state_q;
  assign pll_resetb = pll_resetb_q;
  assign dom_rst    = dom_rst_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed scenarios plus randomized lock/sw_req
// traffic against a time-stamp based reference model.
module tb_rst_sequencer;
  localparam int N   = 4;
  localparam int PRC = 4;
  localparam int LS  = 16;
  localparam int GAP = 8;
`ifdef LOCK_WATCHDOG_EN
  localparam int TIMEOUT = 64;
`else
  localparam int TIMEOUT = 4096;
`endif
  localparam logic [N+7:0] RST_VEC = {2'd0, 1'b0, {N{1'b1}}, 1'b0, 4'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock = 1'b0;
  logic sw_req = 1'b0;
  logic pll_resetb;
  logic [N-1:0] dom_rst;
  logic ready;
  logic [1:0] state;
  logic [3:0] retry_cnt;
  logic [N+7:0] dut_vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .N_DOMAINS(N), .PLL_RST_CYCLES(PRC), .LOCK_STABLE(LS), .GAP(GAP), .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_req(sw_req),
    .pll_resetb(pll_resetb), .dom_rst(dom_rst), .ready(ready),
    .state(state), .retry_cnt(retry_cnt)
  );

  assign dut_vec = {state, pll_resetb, dom_rst, ready, retry_cnt};

  // Reference model: phase plus the edge number at which it was entered; domain
  // releases and timeouts follow from elapsed edges rather than per-state counters.
  int   m_edge = 0, m_phase = 0, m_enter = 0, m_last_low = 0, m_retry = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  task automatic model_step(input logic l, input logic s, input logic r);
    logic ls;
    int el;
    m_edge++;
    if (r) begin
      m_phase = 0; m_enter = m_edge; m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0;
    end else begin
      ls = m_s2;
      el = m_edge - m_enter;
      case (m_phase)
        0: if (el == PRC) begin m_phase = 1; m_enter = m_edge; m_last_low = m_edge; end
        1: begin
          if (!ls) m_last_low = m_edge;
          if (m_edge - m_last_low >= LS) begin
            m_phase = (N == 1) ? 3 : 2; m_enter = m_edge;
          end
`ifdef LOCK_WATCHDOG_EN
          else if (el == TIMEOUT) begin
            m_phase = 0; m_enter = m_edge;
            if (m_retry < 15) m_retry++;
          end
`endif
        end
        default: begin
          if (s) begin
            m_phase = 0; m_enter = m_edge;
          end else if (!ls) begin
            m_phase = 1; m_enter = m_edge; m_last_low = m_edge;
          end else if (m_phase == 2 && (el / GAP + 1) >= N) begin
            m_phase = 3;
          end
        end
      endcase
      m_s2 = m_s1;
      m_s1 = l;
    end
  endtask

  function automatic logic [N+7:0] exp_vec();
    logic [N-1:0] ones, d;
    ones = '1;
    case (m_phase)
      0, 1:    d = ones;
      2:       d = ones << ((m_edge - m_enter) / GAP + 1);
      default: d = '0;
    endcase
    return {2'(m_phase), (m_phase != 0), d, (m_phase == 3), 4'(m_retry)};
  endfunction

  task automatic tick(input logic l, input logic s, input logic r);
    pll_lock = l; sw_req = s; rst = r;
    @(posedge clk);
    model_step(l, s, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      tests++;
      if (dut_vec !== RST_VEC) begin
        fails++; $display("FAIL reset_values: got %h expected %h", dut_vec, RST_VEC);
      end
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_power_up();
    int low, w, rdy;
    int d[N];
    tick(1'b1, 1'b0, 1'b1);
    low = (state === 2'd0) ? 1 : 0;
    w = -1; rdy = -1;
    for (int k = 0; k < N; k++) d[k] = -1;
    for (int c = 1; c <= 120 && rdy < 0; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL power_up_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      if (state === 2'd0) low++;
      if (w < 0 && state === 2'd1) w = c;
      for (int k = 0; k < N; k++) if (d[k] < 0 && dom_rst[k] === 1'b0) d[k] = c;
      if (ready === 1'b1) rdy = c;
    end
    tests++;
    if (low != PRC) begin fails++; $display("FAIL power_up_pll_low: got %0d expected %0d", low, PRC); end
    tests++;
    if (d[0] - w != LS) begin fails++; $display("FAIL power_up_dom0: got %0d expected %0d", d[0] - w, LS); end
    for (int k = 1; k < N; k++) begin
      tests++;
      if (d[k] - d[0] != k * GAP) begin
        fails++; $display("FAIL power_up_dom%0d_gap: got %0d expected %0d", k, d[k] - d[0], k * GAP);
      end
    end
    tests++;
    if (rdy < 0 || rdy != d[N-1]) begin
      fails++; $display("FAIL power_up_ready: got cycle %0d expected %0d", rdy, d[N-1]);
    end
    tests++;
    if (state !== 2'd3 || dom_rst !== '0) begin
      fails++; $display("FAIL power_up_run: got state %0d dom %b expected 3 0000", state, dom_rst);
    end
  endtask

  task automatic test_lock_glitch();
    int d0;
    tick(1'b1, 1'b0, 1'b1);
    d0 = -1;
    for (int c = 1; c <= 60 && d0 < 0; c++) begin
      tick((c == 11) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL glitch_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      if (dom_rst[0] === 1'b0) d0 = c;
    end
    // low sample at tick 11, two-flop lag, then LS uninterrupted high cycles
    tests++;
    if (d0 != 11 + 2 + LS) begin
      fails++; $display("FAIL glitch_release: got %0d expected %0d", d0, 11 + 2 + LS);
    end
  endtask

  task automatic test_lock_loss_run();
    for (int t = 0; t < 100 && ready !== 1'b1; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL loss_prep: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL loss_reach_run: got ready %b expected 1", ready); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL loss_drop %0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (i == 1) begin
        tests++;
        if (state !== 2'd3) begin fails++; $display("FAIL loss_lag: got state %0d expected 3", state); end
      end
      if (i == 2) begin
        tests++;
        if ({state, pll_resetb, dom_rst, ready} !== {2'd1, 1'b1, 4'b1111, 1'b0}) begin
          fails++; $display("FAIL loss_react: got %b expected 01111110", {state, pll_resetb, dom_rst, ready});
        end
      end
    end
    for (int t = 0; t < 100 && ready !== 1'b1; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL loss_recover: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL loss_resequence: got ready %b expected 1", ready); end
  endtask

  task automatic test_sw_lockloss();
    int low;
    tick(1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 100 && dom_rst !== 4'b1100; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL sw_prep: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (dom_rst !== 4'b1100) begin fails++; $display("FAIL sw_reach_1100: got %b expected 1100", dom_rst); end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tests++;
    if ({state, pll_resetb, dom_rst, ready} !== {2'd0, 1'b0, 4'b1111, 1'b0}) begin
      fails++; $display("FAIL sw_priority: got %b expected 00011110", {state, pll_resetb, dom_rst, ready});
    end
    low = 1;
    for (int t = 0; t < 10 && state === 2'd0; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL sw_pllrst: got %h expected %h", dut_vec, exp_vec()); end
      if (pll_resetb === 1'b0) low++;
    end
    tests++;
    if (low != PRC) begin fails++; $display("FAIL sw_pll_low: got %0d expected %0d", low, PRC); end
  endtask

  task automatic test_rst_in_run();
    for (int t = 0; t < 120 && ready !== 1'b1; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL rstrun_prep: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL rstrun_reach_run: got ready %b expected 1", ready); end
    tick(1'b1, 1'b0, 1'b1);
    tests++;
    if (dut_vec !== RST_VEC) begin fails++; $display("FAIL rstrun_values: got %h expected %h", dut_vec, RST_VEC); end
  endtask

`ifdef LOCK_WATCHDOG_EN
  task automatic test_watchdog();
    int wlen, retries;
    logic [1:0] prev;
    tick(1'b0, 1'b0, 1'b1);
    wlen = 0; retries = 0;
    for (int g = 0; g < 2000 && retries < 20; g++) begin
      prev = state;
      tick(1'b0, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL wd_cycle: got %h expected %h", dut_vec, exp_vec()); end
      if (state === 2'd1) wlen++;
      if (prev === 2'd1 && state === 2'd0) begin
        retries++;
        tests++;
        if (wlen != TIMEOUT) begin fails++; $display("FAIL wd_wait_len: got %0d expected %0d", wlen, TIMEOUT); end
        tests++;
        if (retry_cnt !== 4'((retries > 15) ? 15 : retries)) begin
          fails++; $display("FAIL wd_retry: got %0d expected %0d", retry_cnt, (retries > 15) ? 15 : retries);
        end
        wlen = 0;
      end
    end
    tests++;
    if (retries < 20) begin fails++; $display("FAIL wd_retries: got %0d expected 20", retries); end
    for (int t = 0; t < 200 && ready !== 1'b1; t++) begin
      tick(1'b1, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL wd_lock: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (ready !== 1'b1 || retry_cnt !== 4'd15) begin
      fails++; $display("FAIL wd_complete: got ready %b retry %0d expected 1 15", ready, retry_cnt);
    end
  endtask
`else
  task automatic test_no_watchdog();
    tick(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 300; t++) begin
      tick(1'b0, 1'b0, 1'b0);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL nowd_cycle: got %h expected %h", dut_vec, exp_vec()); end
    end
    tests++;
    if ({state, pll_resetb, retry_cnt} !== {2'd1, 1'b1, 4'd0}) begin
      fails++; $display("FAIL nowd_wait: got %b expected 0110000", {state, pll_resetb, retry_cnt});
    end
  endtask
`endif

  task automatic test_random();
    logic l, s, r;
    tick(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      l = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 149) == 0);
      r = ($urandom_range(0, 799) == 0);
      tick(l, s, r);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_lock_loss_run();
    test_sw_lockloss();
    test_rst_in_run();
`ifdef LOCK_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Power-up and recovery sequencer for the PLL-derived clock domain.
- Drives the PLL RESETB pin and waits for a stable PLL lock.
- Releases N downstream domain resets one at a time, in a fixed order with a fixed spacing.
- Re-asserts all domain resets on lock loss or on a software request. Sits beside the PLL/oscillator block and feeds the reset inputs of the DSP/TX datapath.

Parameters:
- N_DOMAINS, 4: number of domain reset outputs; range 1..8.
- PLL_RST_CYCLES, 4: clk cycles that pll_resetb is held low per PLL reset.
- LOCK_STABLE, 16: consecutive cycles the synchronized lock must be high before release starts.
- GAP, 8: clk cycles between successive domain reset releases.
- LOCK_TIMEOUT, 4096: WAIT_LOCK cycle limit before retry (watchdog only).

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- pll_lock, input, 1: PLL LOCK, asynchronous to clk.
- sw_req, input, 1: single-cycle pulse requesting a full re-sequence.
- pll_resetb, output, 1: to PLL RESETB; active low.
- dom_rst, output, N_DOMAINS: per-domain reset; active high; bit 0 is released first.
- ready, output, 1: high when all domains are out of reset.
- state, output, 2: current FSM state code.
- retry_cnt, output, 4: watchdog retry count, saturating.

Behaviour:
- Interface fact: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = PLL_RST (0)
  - pll_resetb = 0
  - dom_rst = all ones
  - ready = 0
  - retry_cnt = 0
  - all internal counters = 0
- pll_lock passes through a 2-flop synchronizer to give lock_s (2-cycle lag). All lock decisions use lock_s.
- FSM encoding: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- PLL_RST:
  - pll_resetb = 0 and dom_rst = all ones.
  - Stays for exactly PLL_RST_CYCLES cycles, then moves to WAIT_LOCK.
  - pll_resetb = 1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Stable counter increments each cycle lock_s = 1 and clears to 0 on any cycle lock_s = 0.
  - When LOCK_STABLE consecutive high cycles have been seen, moves to RELEASE.
  - dom_rst stays all ones.
- RELEASE:
  - Domain index k starts at 0.
  - dom_rst[0] clears on the first RELEASE cycle.
  - dom_rst[k] clears GAP cycles after dom_rst[k-1].
  - Once cleared, a bit stays cleared until a lock-loss or sw_req event.
  - The cycle dom_rst[N_DOMAINS-1] clears, state becomes RUN and ready = 1 in that same cycle.
  - N_DOMAINS=1: dom_rst[0] clears and ready rises together on the first RELEASE cycle.
- RUN: holds; ready = 1, dom_rst = 0.
- Lock loss: lock_s = 0 for one cycle while in RELEASE or RUN causes, on the next cycle:
  - dom_rst = all ones, ready = 0
  - state = WAIT_LOCK, stable counter = 0
  - pll_resetb stays 1
- sw_req:
  - In RELEASE or RUN: next cycle state = PLL_RST, dom_rst = all ones, ready = 0, pll_resetb = 0, PLL_RST timer restarts.
  - Ignored in PLL_RST and WAIT_LOCK.
- Simultaneous sw_req and lock loss: sw_req wins (PLL_RST).
- rst asserted mid-sequence: all outputs return to reset values on the next edge, regardless of state.
- Counter widths: clog2 of the respective parameter, plus 1; no wrap is possible within a state.

Optional Feature:
- Macro: LOCK_WATCHDOG_EN.
- Defined:
  - A timer counts cycles spent in WAIT_LOCK; it clears on entry to WAIT_LOCK.
  - When the timer reaches LOCK_TIMEOUT, state goes to PLL_RST (PLL re-reset) and retry_cnt increments, saturating at 15.
  - retry_cnt is cleared only by rst.
- Not defined: WAIT_LOCK waits indefinitely, no timer logic is built, and retry_cnt is tied to 0.

Test Plan:
- Defaults, rst released, pll_lock = 1 constantly:
  - pll_resetb low for 4 cycles.
  - dom_rst[0] clears 16 cycles after the first WAIT_LOCK cycle with lock_s = 1.
  - dom_rst[1..3] clear at +8, +16, +24; ready rises with dom_rst[3]; state = 3.
- Lock glitches: pll_lock high 10 cycles, low 1 cycle, high again:
  - Stable counter restarts.
  - Release begins only after 16 uninterrupted lock_s cycles.
- Lock loss in RUN: drop pll_lock for 3 cycles:
  - 2 cycles after the drop (synchronizer lag) plus 1, dom_rst = 4'b1111, ready = 0, state = 1, pll_resetb stays 1.
  - Resequence completes after lock returns.
- sw_req in RELEASE when dom_rst = 4'b1100, with lock loss in the same cycle:
  - Next cycle state = 0, pll_resetb = 0 for 4 cycles, dom_rst = 4'b1111.
- rst asserted in RUN: next cycle all outputs at reset values, state = 0.
- LOCK_WATCHDOG_EN, LOCK_TIMEOUT = 64, pll_lock = 0:
  - PLL_RST re-entered every 64 WAIT_LOCK cycles.
  - retry_cnt climbs 1, 2, … and saturates at 15.
  - A later lock completes the sequence with retry_cnt unchanged.
